// File: rtl/i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave
//   I2C slave that behaves like a small 256 x 8 EEPROM. The bus master writes
//   a register address and data bytes, or reads back bytes sequentially from
//   the internal address pointer. All logic runs on the system clock. SCL and
//   SDA are oversampled through 2-flop synchronizers, and edges are detected
//   on the synchronized copies.
//
//   Optional feature macro: I2C_SLAVE_WP_EN
//     When it is defined, i_WP=1 at the 8th bit of a data byte makes the slave
//     NACK that byte. The write is skipped and the pointer stays where it is.
//     When it is not defined, i_WP has no effect.
//
//   Ports
//     i_clk10MHz      system clock, rising edge
//     i_RST_n         asynchronous active-low reset
//     i_SCL, i_SDA    raw I2C bus inputs, asynchronous to i_clk10MHz
//     o_SDA_OE        1 = pull SDA low, 0 = release SDA (open drain)
//     i_WP            write-protect request
//     o_Current_Addr  internal memory address pointer
//     o_Busy          1 while a transaction addressed to this device is open
//
//   Bus handshake: the slave samples SDA only on synchronized SCL rises. It
//   changes its SDA drive only on the clock after a synchronized SCL fall, so
//   its drive never moves while SCL is high. This keeps the slave from
//   creating a false START or STOP.
// ---------------------------------------------------------------------------
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter logic [7:0] MEM_INIT = 8'h00
) (
  input  logic       i_clk10MHz,
  input  logic       i_RST_n,
  input  logic       i_SCL,
  input  logic       i_SDA,
  output logic       o_SDA_OE,
  input  logic       i_WP,
  output logic [7:0] o_Current_Addr,
  output logic       o_Busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  addr_q, addr_d;
  logic        ack_phase_q, ack_phase_d;   // 0: ACK slot not yet driven, 1: driven
  logic        wp_nack_q, wp_nack_d;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem [256];

  logic        scl_rise, scl_fall, start_det, stop_det, wp_block;
  logic [7:0]  shift_in, rd_byte;

`ifdef I2C_SLAVE_WP_EN
  assign wp_block = i_WP;
`else
  assign wp_block = i_WP & 1'b0;
`endif

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  // SCL must be high on both samples. Then an SDA change that arrives in the
  // same cycle as an SCL fall is not mistaken for START or STOP.
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign shift_in  = {shreg_q[6:0], sda_s2};
  assign rd_byte   = mem[addr_q];

  assign o_SDA_OE       = oe_q;
  assign o_Busy         = busy_q;
  assign o_Current_Addr = addr_q;

  // Synchronizers and the edge-detect history. They reset to the idle bus level.
  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= i_SCL;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= i_SDA;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'h00;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= 8'h00;
      ack_phase_q <= 1'b0;
      wp_nack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      ack_phase_q <= ack_phase_d;
      wp_nack_q   <= wp_nack_d;
    end
  end

  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= MEM_INIT;
    end else if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    ack_phase_d = ack_phase_q;
    wp_nack_d   = wp_nack_q;
    mem_we      = 1'b0;
    mem_wdata   = shift_in;

    if (start_det) begin
      // A repeated START keeps the pointer, so a random read works.
      state_d     = ST_DEV_ADDR;
      bit_cnt_d   = 4'd0;
      oe_d        = 1'b0;
      ack_phase_d = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 4'd0;
      oe_d        = 1'b0;
      busy_d      = 1'b0;
      ack_phase_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;

        ST_DEV_ADDR: if (scl_rise) begin
          shreg_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d   = 4'd0;
            ack_phase_d = 1'b0;
            state_d     = (shift_in[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IDLE;
          end
        end

        // shreg_q[0] still holds the R/W bit of the address byte.
        ST_DEV_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            oe_d        = 1'b1;
            busy_d      = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            ack_phase_d = 1'b0;
            if (shreg_q[0]) begin
              state_d = ST_RD_DATA;
              shreg_d = rd_byte;
              oe_d    = ~rd_byte[7];
            end else begin
              state_d = ST_REG_ADDR;
              oe_d    = 1'b0;
            end
          end
        end

        ST_REG_ADDR: if (scl_rise) begin
          shreg_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d   = 4'd0;
            addr_d      = shift_in;
            ack_phase_d = 1'b0;
            state_d     = ST_REG_ACK;
          end
        end

        ST_REG_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            oe_d        = 1'b1;
            ack_phase_d = 1'b1;
          end else begin
            oe_d        = 1'b0;
            ack_phase_d = 1'b0;
            state_d     = ST_WR_DATA;
          end
        end

        ST_WR_DATA: if (scl_rise) begin
          shreg_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d   = 4'd0;
            ack_phase_d = 1'b0;
            state_d     = ST_WR_ACK;
            if (wp_block) begin
              wp_nack_d = 1'b1;
            end else begin
              wp_nack_d = 1'b0;
              mem_we    = 1'b1;
              addr_d    = addr_q + 8'd1;
            end
          end
        end

        ST_WR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            oe_d        = ~wp_nack_q;
            ack_phase_d = 1'b1;
          end else begin
            oe_d        = 1'b0;
            ack_phase_d = 1'b0;
            state_d     = ST_WR_DATA;
          end
        end

        // Bit 7 is already on the bus when this state is entered. Each fall
        // after rises 1..7 puts the next bit out. The fall after rise 8
        // releases SDA for the master's ACK.
        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d   = 4'd0;
              oe_d        = 1'b0;
              ack_phase_d = 1'b0;
              state_d     = ST_RD_ACK;
            end else if (bit_cnt_q != 4'd0) begin
              oe_d    = ~shreg_q[6];
              shreg_d = {shreg_q[6:0], 1'b0};
            end
          end
        end

        // The pointer advances on the ACK/NACK sample. After an ACK, the next
        // byte is loaded from the new pointer on the following fall.
        ST_RD_ACK: begin
          if (scl_rise) begin
            addr_d = addr_q + 8'd1;
            if (sda_s2) state_d = ST_IDLE;
            else        ack_phase_d = 1'b1;
          end else if (scl_fall && ack_phase_q) begin
            ack_phase_d = 1'b0;
            state_d     = ST_RD_DATA;
            shreg_d     = rd_byte;
            oe_d        = ~rd_byte[7];
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
